// File: rtl/trees_pred_packer.sv
// Packs 8-bit class results into 64-bit words of a result buffer read by the DMA.
// Optional out-of-range class checking is enabled by TREES_PRED_RANGE_CHK_EN.
module trees_pred_packer #(
  parameter int N_CLASES  = 32,
  parameter int MAX_BURST = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] burst_len,
  input  logic        class_valid,
  output logic        class_ready,
  input  logic [7:0]  class_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] count,
  input  logic [31:0] rd_addr,
  output logic [63:0] rd_data,
  output logic        range_err
);

  localparam int DEPTH = (MAX_BURST + 7) / 8;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (N_CLASES < 1 || N_CLASES > 256) begin : g_bad_classes
    $error("N_CLASES must be in 1..256");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] len;
  logic [63:0] acc;
  logic [63:0] mem [DEPTH];

  logic [31:0] cap_len;
  logic        launch;
  logic        accept;
  logic [2:0]  lane;
  logic        last;
  logic        wr;
  logic [7:0]  stored;
  logic [63:0] word;

  assign cap_len = (burst_len > 32'(MAX_BURST)) ? 32'(MAX_BURST) : burst_len;
  assign launch  = start && (state != S_DONE);
  assign accept  = class_valid && class_ready && !launch;
  assign lane    = count[2:0];
  assign last    = (count == len - 32'd1);
  assign wr      = accept && ((lane == 3'd7) || last);

`ifdef TREES_PRED_RANGE_CHK_EN
  logic bad;
  assign bad    = ({24'd0, class_data} >= 32'(N_CLASES));
  assign stored = bad ? 8'hFF : class_data;
`else
  assign stored    = class_data;
  assign range_err = 1'b0;
`endif

  assign word = acc | (64'(stored) << {lane, 3'b000});

  always_ff @(posedge clk) begin
    if (wr) mem[count[AW+2:3]] <= word;
  end

  assign rd_data = (rd_addr < 32'(DEPTH)) ? mem[rd_addr[AW-1:0]] : 64'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len         <= 32'd0;
      acc         <= 64'd0;
      count       <= 32'd0;
      busy        <= 1'b0;
      class_ready <= 1'b0;
      done        <= 1'b0;
`ifdef TREES_PRED_RANGE_CHK_EN
      range_err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (launch) begin
        count <= 32'd0;
        acc   <= 64'd0;
        if (burst_len != 32'd0) begin
          len         <= cap_len;
          state       <= S_COLLECT;
          busy        <= 1'b1;
          class_ready <= 1'b1;
`ifdef TREES_PRED_RANGE_CHK_EN
          range_err   <= 1'b0;
`endif
        end else begin
          state       <= S_DONE;
          busy        <= 1'b0;
          class_ready <= 1'b0;
          done        <= 1'b1;
        end
      end else begin
        unique case (state)
          S_IDLE: ;
          S_COLLECT: begin
            if (accept) begin
              count <= count + 32'd1;
              acc   <= wr ? 64'd0 : word;
`ifdef TREES_PRED_RANGE_CHK_EN
              if (bad) range_err <= 1'b1;
`endif
              if (last) begin
                state       <= S_DONE;
                busy        <= 1'b0;
                class_ready <= 1'b0;
                done        <= 1'b1;
              end
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trees_pred_packer.sv
// Directed self-checking bench for trees_pred_packer.
// Expected words are hand-computed from the byte-lane packing rule.
module tb_trees_pred_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] burst_len;
  logic        class_valid;
  logic        class_ready;
  logic [7:0]  class_data;
  logic        busy;
  logic        done;
  logic [31:0] count;
  logic [31:0] rd_addr;
  logic [63:0] rd_data;
  logic        range_err;

  int nv = 0;
  int nerr = 0;
  int dn = 0;

  trees_pred_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .class_valid(class_valid), .class_ready(class_ready),
    .class_data(class_data), .busy(busy), .done(done), .count(count),
    .rd_addr(rd_addr), .rd_data(rd_data), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (done) dn++;
  endtask

  task automatic start_burst(input logic [31:0] l);
    start = 1'b1;
    burst_len = l;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    burst_len = 32'd0;
    class_valid = 1'b0;
    class_data = 8'd0;
    rd_addr = 32'd0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    nv++;
    if ({class_ready, busy, done, range_err} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_flags got %b want 0000",
               {class_ready, busy, done, range_err});
    end
    nv++;
    if (count !== 32'd0) begin
      nerr++;
      $display("FAIL reset_count got %0d want 0", count);
    end
  endtask

  task automatic test_back_to_back();
    dn = 0;
    start_burst(32'd16);
    nv++;
    if ({busy, class_ready} !== 2'b11) begin
      nerr++;
      $display("FAIL b2b_ready got %b want 11", {busy, class_ready});
    end
    for (int i = 0; i < 16; i++) begin
      class_valid = 1'b1;
      class_data = 8'(i);
      cyc();
      if (i == 7) begin
        rd_addr = 32'd0;
        #1;
        nv++;
        if (rd_data !== 64'h0706050403020100) begin
          nerr++;
          $display("FAIL b2b_w0_early got %h want 0706050403020100",
                   rd_data);
        end
      end
    end
    class_valid = 1'b0;
    nv++;
    if ({done, busy, count} !== {2'b10, 32'd16}) begin
      nerr++;
      $display("FAIL b2b_end done=%b busy=%b count=%0d want 1 0 16",
               done, busy, count);
    end
    cyc();
    rd_addr = 32'd1;
    #1;
    nv++;
    if (rd_data !== 64'h0F0E0D0C0B0A0908) begin
      nerr++;
      $display("FAIL b2b_w1 got %h want 0F0E0D0C0B0A0908", rd_data);
    end
    nv++;
    if ({dn, done, class_ready} !== {32'd1, 2'b00}) begin
      nerr++;
      $display("FAIL b2b_pulse dn=%0d done=%b ready=%b want 1 0 0",
               dn, done, class_ready);
    end
  endtask

  task automatic test_gaps();
    logic [5:0] vpat;
    logic [7:0] vals [3];
    int k;
    vpat = 6'b100101;
    vals[0] = 8'd5;
    vals[1] = 8'd6;
    vals[2] = 8'd7;
    k = 0;
    dn = 0;
    start_burst(32'd3);
    for (int i = 0; i < 6; i++) begin
      class_valid = vpat[i];
      class_data = vpat[i] ? vals[k] : 8'hAA;
      if (vpat[i]) k++;
      cyc();
      if (i < 5) begin
        nv++;
        if (done !== 1'b0) begin
          nerr++;
          $display("FAIL gap_early_done step %0d got 1 want 0", i);
        end
      end
    end
    class_valid = 1'b0;
    nv++;
    if ({done, count} !== {1'b1, 32'd3}) begin
      nerr++;
      $display("FAIL gap_done done=%b count=%0d want 1 3", done, count);
    end
    cyc();
    rd_addr = 32'd0;
    #1;
    nv++;
    if ({class_ready, done} !== 2'b00 || dn != 1) begin
      nerr++;
      $display("FAIL gap_after ready=%b done=%b dn=%0d want 0 0 1",
               class_ready, done, dn);
    end
    nv++;
    if (rd_data !== 64'h0000000000070605) begin
      nerr++;
      $display("FAIL gap_w0 got %h want 0000000000070605", rd_data);
    end
  endtask

  task automatic test_zero_len();
    dn = 0;
    start_burst(32'd0);
    nv++;
    if ({done, busy, count} !== {2'b10, 32'd0}) begin
      nerr++;
      $display("FAIL zero_done done=%b busy=%b count=%0d want 1 0 0",
               done, busy, count);
    end
    start_burst(32'd4);
    nv++;
    if ({done, busy, class_ready} !== 3'b000) begin
      nerr++;
      $display("FAIL zero_start_in_done got %b want 000",
               {done, busy, class_ready});
    end
    rd_addr = 32'd0;
    #1;
    nv++;
    if (rd_data !== 64'h0000000000070605) begin
      nerr++;
      $display("FAIL zero_keep_w0 got %h want 0000000000070605", rd_data);
    end
  endtask

  task automatic test_restart();
    dn = 0;
    start_burst(32'd10);
    for (int i = 0; i < 5; i++) begin
      class_valid = 1'b1;
      class_data = 8'd9;
      cyc();
    end
    class_valid = 1'b0;
    start_burst(32'd2);
    nv++;
    if ({busy, count} !== {1'b1, 32'd0}) begin
      nerr++;
      $display("FAIL rst_restart busy=%b count=%0d want 1 0", busy, count);
    end
    class_valid = 1'b1;
    class_data = 8'd1;
    cyc();
    class_data = 8'd2;
    cyc();
    class_valid = 1'b0;
    cyc();
    rd_addr = 32'd0;
    #1;
    nv++;
    if (rd_data !== 64'h0000000000000201 || count !== 32'd2 || dn != 1) begin
      nerr++;
      $display("FAIL restart_result w0=%h count=%0d dn=%0d want 201 2 1",
               rd_data, count, dn);
    end
  endtask

  task automatic test_max_burst();
    int acc;
    int budget;
    acc = 0;
    budget = 0;
    dn = 0;
    start_burst(32'd6000);
    while (dn == 0 && budget < 6000) begin
      class_valid = 1'b1;
      class_data = 8'(acc % 32);
      if (class_ready) acc++;
      cyc();
      budget++;
    end
    class_valid = 1'b0;
    nv++;
    if (dn != 1 || acc != 5000 || count !== 32'd5000) begin
      nerr++;
      $display("FAIL max_len dn=%0d accepts=%0d count=%0d want 1 5000 5000",
               dn, acc, count);
    end
    rd_addr = 32'd625;
    #1;
    nv++;
    if (rd_data !== 64'd0) begin
      nerr++;
      $display("FAIL max_oob got %h want 0", rd_data);
    end
    rd_addr = 32'd624;
    #1;
    nv++;
    if (rd_data !== 64'h0706050403020100) begin
      nerr++;
      $display("FAIL max_w624 got %h want 0706050403020100", rd_data);
    end
    rd_addr = 32'd623;
    #1;
    nv++;
    if (rd_data !== 64'h1F1E1D1C1B1A1918) begin
      nerr++;
      $display("FAIL max_w623 got %h want 1F1E1D1C1B1A1918", rd_data);
    end
    cyc();
  endtask

  task automatic test_range();
    logic [63:0] ew;
    logic        ee;
`ifdef TREES_PRED_RANGE_CHK_EN
    ew = 64'h03FF;
    ee = 1'b1;
`else
    ew = 64'h0328;
    ee = 1'b0;
`endif
    start_burst(32'd2);
    class_valid = 1'b1;
    class_data = 8'd40;
    cyc();
    class_data = 8'd3;
    cyc();
    class_valid = 1'b0;
    rd_addr = 32'd0;
    #1;
    nv++;
    if (rd_data !== ew) begin
      nerr++;
      $display("FAIL range_w0 got %h want %h", rd_data, ew);
    end
    cyc();
    cyc();
    nv++;
    if (range_err !== ee) begin
      nerr++;
      $display("FAIL range_sticky got %b want %b", range_err, ee);
    end
    start_burst(32'd1);
    nv++;
    if (range_err !== 1'b0) begin
      nerr++;
      $display("FAIL range_clear got %b want 0", range_err);
    end
    class_valid = 1'b1;
    class_data = 8'd4;
    cyc();
    class_valid = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_zero_len();
    test_restart();
    test_max_burst();
    test_range();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end

endmodule
